// File: rtl/alu_exec_unit.sv
// Execute stage of the 16-bit CPU: single-cycle add/sub, iterative shift-add
// multiply and restoring divide, with registered results and writeback tag.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       opcode_i,
  input  logic [WIDTH-1:0] rs1_val_i,
  input  logic [WIDTH-1:0] rs2_val_i,
  input  logic [2:0]       rd_addr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [2:0]       rd_addr_out_o,
  output logic             overflow_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;     // multiplicand or divisor
  logic [WIDTH-1:0]   work_q, work_d;   // multiplier, or dividend shifting into quotient
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [2:0]         rd_q, rd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [2:0]         rd_out_q, rd_out_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;

  logic [PROD_W:0]    mul_sum;
  logic [PROD_W-1:0]  prod_nxt;
  logic [WIDTH:0]     rem_sh;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quot_nxt;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic               last_iter;

  // One iteration of each multi-cycle datapath, evaluated every cycle
  always_comb begin
    mul_sum   = {1'b0, prod_q} + (work_q[0] ? {1'b0, opa_q, WIDTH'(0)} : (PROD_W + 1)'(0));
    prod_nxt  = mul_sum[PROD_W:1];
    rem_sh    = {rem_q, work_q[WIDTH-1]};
    q_bit     = (rem_sh >= {1'b0, opa_q});
    rem_nxt   = q_bit ? WIDTH'(rem_sh - {1'b0, opa_q}) : rem_sh[WIDTH-1:0];
    quot_nxt  = {work_q[WIDTH-2:0], q_bit};
    add_full  = {1'b0, rs1_val_i} + {1'b0, rs2_val_i};
    sub_full  = {1'b0, rs1_val_i} - {1'b0, rs2_val_i};
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    work_d   = work_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    rd_d     = rd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    rd_out_d = rd_out_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rd_d = rd_addr_i;
          cnt_d = '0;
          unique case (opcode_i)
            2'b00, 2'b01: begin
              done_d   = 1'b1;
              rd_out_d = rd_addr_i;
              res_hi_d = '0;
              dbz_d    = 1'b0;
              if (opcode_i == 2'b00) begin
                res_d = add_full[WIDTH-1:0];
                ovf_d = add_full[WIDTH];
              end else begin
                res_d = sub_full[WIDTH-1:0];
                ovf_d = sub_full[WIDTH];
              end
            end
            2'b10: begin
              state_d = S_MUL;
              busy_d  = 1'b1;
              opa_d   = rs1_val_i;
              work_d  = rs2_val_i;
              prod_d  = '0;
            end
            default: begin
              // A zero divisor completes immediately with a fixed result
              if (rs2_val_i == '0) begin
                done_d   = 1'b1;
                rd_out_d = rd_addr_i;
                res_d    = '1;
                res_hi_d = rs1_val_i;
                ovf_d    = 1'b0;
                dbz_d    = 1'b1;
              end else begin
                state_d = S_DIV;
                busy_d  = 1'b1;
                opa_d   = rs2_val_i;
                work_d  = rs1_val_i;
                rem_d   = '0;
              end
            end
          endcase
        end
      end
      S_MUL: begin
        prod_d = prod_nxt;
        work_d = work_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          res_d    = prod_nxt[WIDTH-1:0];
          res_hi_d = prod_nxt[PROD_W-1:WIDTH];
          rd_out_d = rd_q;
          ovf_d    = 1'b0;
          dbz_d    = 1'b0;
        end
      end
      S_DIV: begin
        rem_d  = rem_nxt;
        work_d = quot_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          res_d    = quot_nxt;
          res_hi_d = rem_nxt;
          rd_out_d = rd_q;
          ovf_d    = 1'b0;
          dbz_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      work_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      rd_out_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      work_q   <= work_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      rd_out_q <= rd_out_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign result_o      = res_q;
  assign result_hi_o   = res_hi_q;
  assign rd_addr_out_o = rd_out_q;
  assign overflow_o    = ovf_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, randomized ops
// against an arithmetic reference model, and hand-written busy/reset sequences.
module tb_alu_exec_unit;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    opcode;
  logic [W-1:0]  rs1, rs2;
  logic [2:0]    rd;
  logic          busy, done, ovf, dbz;
  logic [W-1:0]  res, res_hi;
  logic [2:0]    rd_out;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .opcode_i(opcode),
    .rs1_val_i(rs1), .rs2_val_i(rs2), .rd_addr_i(rd),
    .busy_o(busy), .done_o(done), .result_o(res), .result_hi_o(res_hi),
    .rd_addr_out_o(rd_out), .overflow_o(ovf), .div_by_zero_o(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_res;
    logic [W-1:0] e_hi;
    logic         e_ovf;
    logic         e_dbz;
    int           e_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".busy"}, 32'(busy), 32'd0);
    check({name, ".done"}, 32'(done), 32'd0);
    check({name, ".result"}, 32'(res), 32'd0);
    check({name, ".result_hi"}, 32'(res_hi), 32'd0);
    check({name, ".rd_out"}, 32'(rd_out), 32'd0);
    check({name, ".flags"}, {30'd0, ovf, dbz}, 32'd0);
  endtask

  // Issue one op, scramble inputs after acceptance, wait for done (bounded)
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] tag, output int lat, output int busy_cycles);
    @(negedge clk);
    start = 1'b1; opcode = op; rs1 = a; rs2 = b; rd = tag;
    @(posedge clk); #1;
    start = 1'b0; opcode = 2'($urandom); rs1 = W'($urandom); rs2 = W'($urandom); rd = 3'($urandom);
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic verify(input string name, input vec_t v, input logic [2:0] tag);
    int lat, bc;
    run_op(v.op, v.a, v.b, tag, lat, bc);
    check({name, ".latency"}, 32'(lat), 32'(v.e_lat));
    check({name, ".busy_cycles"}, 32'(bc), 32'(v.e_lat - 1));
    check({name, ".busy_at_done"}, 32'(busy), 32'd0);
    check({name, ".result"}, 32'(res), 32'(v.e_res));
    check({name, ".result_hi"}, 32'(res_hi), 32'(v.e_hi));
    check({name, ".overflow"}, 32'(ovf), 32'(v.e_ovf));
    check({name, ".div_by_zero"}, 32'(dbz), 32'(v.e_dbz));
    check({name, ".rd_out"}, 32'(rd_out), 32'(tag));
    @(posedge clk); #1;
    check({name, ".done_one_cycle"}, 32'(done), 32'd0);
  endtask

  // Reference model: plain unsigned arithmetic
  function automatic vec_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    v.op = op; v.a = a; v.b = b;
    v.e_hi = '0; v.e_ovf = 1'b0; v.e_dbz = 1'b0; v.e_lat = 1;
    case (op)
      2'd0: begin s = {1'b0, a} + {1'b0, b}; v.e_res = s[W-1:0]; v.e_ovf = s[W]; end
      2'd1: begin s = {1'b0, a} - {1'b0, b}; v.e_res = s[W-1:0]; v.e_ovf = s[W]; end
      2'd2: begin
        p = (2*W)'(a) * (2*W)'(b);
        v.e_res = p[W-1:0]; v.e_hi = p[2*W-1:W]; v.e_lat = W + 1;
      end
      default: begin
        if (b == 0) begin
          v.e_res = '1; v.e_hi = a; v.e_dbz = 1'b1;
        end else begin
          v.e_res = a / b; v.e_hi = a % b; v.e_lat = W + 1;
        end
      end
    endcase
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    int lat, cyc, dones;
    vec_t v;
    logic [1:0] op;
    logic [W-1:0] a, b;

    rst = 1'b1; start = 1'b0; opcode = '0; rs1 = '0; rs2 = '0; rd = '0;
    #3;
    check_all_zero("reset_initial");
    @(negedge clk); rst = 1'b0;

    tbl[0] = '{2'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1};
    tbl[1] = '{2'd1, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1};
    tbl[2] = '{2'd2, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 1'b0, 17};
    tbl[3] = '{2'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 17};
    tbl[4] = '{2'd3, 16'd1000, 16'd7,    16'h008E, 16'h0006, 1'b0, 1'b0, 17};
    tbl[5] = '{2'd3, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1};
    tbl[6] = '{2'd0, 16'h1234, 16'h4321, 16'h5555, 16'h0000, 1'b0, 1'b0, 1};
    tbl[7] = '{2'd1, 16'h0007, 16'h0005, 16'h0002, 16'h0000, 1'b0, 1'b0, 1};
    tbl[8] = '{2'd3, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 1'b0, 17};
    tbl[9] = '{2'd3, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};

    for (int i = 0; i < 10; i++)
      verify($sformatf("vec%0d", i), tbl[i], 3'((i == 0) ? 3 : i));

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = W'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
      v  = model(op, a, b);
      verify($sformatf("rand%0d", i), v, 3'($urandom));
    end

    // Start while busy is ignored; a start in the done cycle is accepted
    @(negedge clk);
    start = 1'b1; opcode = 2'd2; rs1 = 16'h1234; rs2 = 16'h0010; rd = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; dones = 0;
    while (!done && cyc < 40) begin
      if (cyc == 4) begin start = 1'b1; opcode = 2'd0; rs1 = 16'h0001; rs2 = 16'h0001; rd = 3'd2; end
      if (cyc == 5) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_ignore.latency", 32'(cyc), 32'd17);
    check("busy_ignore.result", {res_hi, res}, 32'h0001_2340);
    check("busy_ignore.rd_out", 32'(rd_out), 32'd5);
    start = 1'b1; opcode = 2'd0; rs1 = 16'h0002; rs2 = 16'h0003; rd = 3'd6;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.done", 32'(done), 32'd1);
    check("b2b.result", 32'(res), 32'h0005);
    check("b2b.rd_out", 32'(rd_out), 32'd6);

    // Async reset between edges clears outputs immediately
    @(negedge clk); #2;
    rst = 1'b1; #1;
    check_all_zero("reset_async");
    @(negedge clk); rst = 1'b0;

    // Reset in the middle of a multiply aborts it without a done
    @(negedge clk);
    start = 1'b1; opcode = 2'd2; rs1 = 16'hFFFF; rs2 = 16'hFFFF; rd = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 8; c++) begin @(posedge clk); #1; end
    check("mid_mul.busy_before", 32'(busy), 32'd1);
    rst = 1'b1; #1;
    check_all_zero("mid_mul_reset");
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; if (done || busy) dones++; end
    check("mid_mul.no_done", 32'(dones), 32'd0);
    verify("after_reset_add", model(2'd0, 16'h0100, 16'h0023), 3'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
